// File: rtl/arb2_4_pkg.sv
// ---------------------------------------------------------------------------
// arb2_4_pkg
//   Shared constants for the two-requester arbiter around mux2_4.
//   DATA_W   : datapath width (fixed at 4 by mux2_4)
//   word_t   : one datapath word
//   ST_*     : FSM state encodings (IDLE=0, OWN_A=1, OWN_B=2)
// ---------------------------------------------------------------------------
package arb2_4_pkg;

    localparam int DATA_W = 4;

    typedef logic [DATA_W-1:0] word_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_A = 2'd1;
    localparam logic [1:0] ST_OWN_B = 2'd2;

endpackage : arb2_4_pkg

// File: rtl/arb2_4_mux2_4.sv
// ---------------------------------------------------------------------------
// mux2_4
//   4-bit two-input multiplexer; the shared datapath arbitrated by arb2_4.
//   out : selected word
//   a   : word returned when s = 0
//   b   : word returned when s = 1
//   s   : select
// ---------------------------------------------------------------------------
module mux2_4
    import arb2_4_pkg::*;
(
    output word_t out,
    input  word_t a,
    input  word_t b,
    input  logic  s
);

    assign out = s ? b : a;

endmodule : mux2_4

// File: rtl/arb2_4.sv
// ---------------------------------------------------------------------------
// arb2_4
//   Round-robin arbiter and sequencer for two requesters sharing mux2_4.
//   The owner's word is registered onto o_bus_out with o_bus_valid. An owner
//   is forced off after HOLD_MAX consecutive cycles while the other side is
//   requesting, so neither side can starve the other.
//
//   i_clk        : clock, rising edge
//   i_reset      : synchronous active-high reset
//   i_req_a/b    : level request, held until done
//   i_done_a/b   : release pulse, only honoured from the current owner
//   i_data_a/b   : requester words
//   o_gnt_a/b    : registered grants, never both high
//   o_sel        : registered mux select (0 = A, 1 = B), held while idle
//   o_bus_out    : registered mux output
//   o_bus_valid  : o_bus_out carries a word captured from the owner
// ---------------------------------------------------------------------------
module arb2_4
    import arb2_4_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic  i_clk,
    input  logic  i_reset,
    input  logic  i_req_a,
    input  logic  i_req_b,
    input  logic  i_done_a,
    input  logic  i_done_b,
    input  word_t i_data_a,
    input  word_t i_data_b,
    output logic  o_gnt_a,
    output logic  o_gnt_b,
    output logic  o_sel,
    output word_t o_bus_out,
    output logic  o_bus_valid
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    logic [1:0]       r_state;
    logic             r_last_b;     // 1: B was the most recent owner
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_sel;
    word_t            r_bus_out;
    logic             r_bus_valid;

    logic       w_own_a;
    logic       w_own_b;
    logic       w_mine_req;
    logic       w_mine_done;
    logic       w_other_req;
    logic       w_release;
    logic [1:0] w_state_nxt;
    word_t      w_mux_out;

    mux2_4 u_mux (
        .out (w_mux_out),
        .a   (i_data_a),
        .b   (i_data_b),
        .s   (r_sel)
    );

    // NOTE: every signal assigned in this block gets a value before any
    // branch, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_own_a     = (r_state == ST_OWN_A);
        w_own_b     = (r_state == ST_OWN_B);
        // Fold both owner states onto "mine" / "other" so one release rule serves both.
        w_mine_req  = w_own_a ? i_req_a  : i_req_b;
        w_mine_done = w_own_a ? i_done_a : i_done_b;
        w_other_req = w_own_a ? i_req_b  : i_req_a;
        w_release   = (w_own_a || w_own_b) &&
                      (w_mine_done || !w_mine_req ||
                       ((r_hold_cnt == HOLD_LAST) && w_other_req));

        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                // On a tie the side that did not own last wins.
                if (i_req_a && (!i_req_b || r_last_b)) w_state_nxt = ST_OWN_A;
                else if (i_req_b)                      w_state_nxt = ST_OWN_B;
            end
            ST_OWN_A: if (w_release) w_state_nxt = i_req_b ? ST_OWN_B : ST_IDLE;
            ST_OWN_B: if (w_release) w_state_nxt = i_req_a ? ST_OWN_A : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_last_b    <= 1'b1;
            r_hold_cnt  <= '0;
            r_sel       <= 1'b0;
            r_bus_out   <= '0;
            r_bus_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bus_out   <= w_mux_out;
            r_bus_valid <= w_own_a || w_own_b;

            if (w_release) r_last_b <= w_own_b;

            // Count only while keeping ownership; saturate at the release
            // threshold so a long solo owner yields on the first competing request.
            if ((w_state_nxt == r_state) && (r_state != ST_IDLE)) begin
                if (r_hold_cnt != HOLD_LAST) r_hold_cnt <= r_hold_cnt + 1'b1;
            end else begin
                r_hold_cnt <= '0;
            end

            if (w_state_nxt == ST_OWN_A)      r_sel <= 1'b0;
            else if (w_state_nxt == ST_OWN_B) r_sel <= 1'b1;
        end
    end

    assign o_gnt_a     = (r_state == ST_OWN_A);
    assign o_gnt_b     = (r_state == ST_OWN_B);
    assign o_sel       = r_sel;
    assign o_bus_out   = r_bus_out;
    assign o_bus_valid = r_bus_valid;

endmodule : arb2_4
